vend_seq_ctrl: RTL

VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

---
 rtl/vend_seq_ctrl_if.sv | 25 ++
 rtl/vend_seq_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vend_seq_ctrl_if.sv
// Handshake bundle for the vending sequencer: coin, keypad and acknowledge
// pulses in, dispenser/change requests and credit status out.
interface vend_seq_ctrl_if;
  logic       coin5;
  logic       coin10;
  logic       sel;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic       chg_req;
  logic       coin_reject;
  logic [5:0] credit;
  logic       busy;

  modport master (
    output coin5, coin10, sel, cancel, disp_ack, chg_ack,
    input  disp_req, chg_req, coin_reject, credit, busy
  );

  modport slave (
    input  coin5, coin10, sel, cancel, disp_ack, chg_ack,
    output disp_req, chg_req, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: accumulates coin credit, dispenses one item per purchase,
// then pays change (or a full refund) one 5-unit coin per change-unit handshake.
module vend_seq_ctrl #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 30,
  parameter int TIMEOUT    = 1000
) (
  input  logic           clk,
  input  logic           reset,
  vend_seq_ctrl_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CREDIT   = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3,
    S_REFUND   = 3'd4
  } state_t;

  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0]    PRICE_W    = 7'(PRICE);
  localparam logic [6:0]    MAX_W      = 7'(MAX_CREDIT);
  localparam logic [5:0]    PRICE_C    = 6'(PRICE);

  state_t        r_state;
  logic [5:0]    r_credit;
  logic [TW-1:0] r_timer;
  logic          r_disp_req;
  logic          r_chg_req;
  logic          r_coin_reject;

  logic          w_coin_any;
  logic          w_coin_one;
  logic [6:0]    w_coin_val;
  logic [6:0]    w_sum;
  logic          w_fits;
  logic          w_open;
  logic          w_sel_ok;
  logic          w_cancel_ok;
  logic          w_coin_accept;

  // Coin acceptance: a coin loses to an acted-on cancel or sel in the same cycle.
  always_comb begin
    w_coin_any = io_bus.coin5 | io_bus.coin10;
    w_coin_one = io_bus.coin5 ^ io_bus.coin10;
    if (io_bus.coin10) begin
      w_coin_val = 7'd10;
    end else begin
      w_coin_val = 7'd5;
    end
    w_sum         = {1'b0, r_credit} + w_coin_val;
    w_fits        = (w_sum <= MAX_W);
    w_open        = (r_state == S_IDLE) || (r_state == S_CREDIT);
    w_sel_ok      = (r_state == S_CREDIT) && io_bus.sel && ({1'b0, r_credit} >= PRICE_W);
    w_cancel_ok   = (r_state == S_CREDIT) && io_bus.cancel;
    w_coin_accept = w_open && w_coin_one && w_fits && !w_cancel_ok && !w_sel_ok;
  end

  // Sequencer state, credit, idle timer and registered request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_credit      <= 6'd0;
      r_timer       <= TW'(0);
      r_disp_req    <= 1'b0;
      r_chg_req     <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_coin_reject <= w_coin_any & ~w_coin_accept;
      case (r_state)
        S_IDLE: begin
          r_timer <= TW'(0);
          if (w_coin_accept) begin
            r_credit <= w_sum[5:0];
            r_state  <= S_CREDIT;
          end else begin
            r_credit <= 6'd0;
          end
        end
        S_CREDIT: begin
          if (w_cancel_ok) begin
            r_state   <= S_REFUND;
            r_chg_req <= 1'b1;
            r_timer   <= TW'(0);
          end else if (w_sel_ok) begin
            r_credit   <= r_credit - PRICE_C;
            r_state    <= S_DISPENSE;
            r_disp_req <= 1'b1;
            r_timer    <= TW'(0);
          end else if (w_coin_accept) begin
            r_credit <= w_sum[5:0];
            r_timer  <= TW'(0);
          end else if (r_timer == TIMER_LAST) begin
            // Abandoned session: return everything inserted so far.
            r_state   <= S_REFUND;
            r_chg_req <= 1'b1;
            r_timer   <= TW'(0);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DISPENSE: begin
          if (io_bus.disp_ack) begin
            r_disp_req <= 1'b0;
            if (r_credit != 6'd0) begin
              r_state   <= S_CHANGE;
              r_chg_req <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_CHANGE, S_REFUND: begin
          if (io_bus.chg_ack) begin
            r_credit <= r_credit - 6'd5;
            if (r_credit == 6'd5) begin
              r_state   <= S_IDLE;
              r_chg_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_credit   <= 6'd0;
          r_timer    <= TW'(0);
          r_disp_req <= 1'b0;
          r_chg_req  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.disp_req    = r_disp_req;
  assign io_bus.chg_req     = r_chg_req;
  assign io_bus.coin_reject = r_coin_reject;
  assign io_bus.credit      = r_credit;
  assign io_bus.busy        = (r_state == S_DISPENSE) || (r_state == S_CHANGE) ||
                              (r_state == S_REFUND);

endmodule
